vga_timing_gen: RTL

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

---
 rtl/vga_timing_gen.sv | 103 ++++++++++
 1 files changed

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel/line counters with registered,
// zero-skew sync and blank outputs plus a per-frame pulse and counter.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33
) (
  input  logic       vga_clk,
  input  logic       reset_n,
  input  logic       en,
  output logic       hs,
  output logic       vs,
  output logic       blank,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       frame_start,
  output logic [7:0] frame_count
);

  localparam logic [9:0] H_TOTAL  = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP);
  localparam logic [9:0] V_TOTAL  = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP);
  localparam logic [9:0] H_LAST   = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_LAST   = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [9:0] r_x;
  logic [9:0] r_y;
  logic       r_hs;
  logic       r_vs;
  logic       r_blank;
  logic       r_frame_start;
  logic [7:0] r_frame_count;

  logic [9:0] w_x_nxt;
  logic [9:0] w_y_nxt;
  logic       w_x_wrap;
  logic       w_frame_wrap;
  logic       w_hs_nxt;
  logic       w_vs_nxt;
  logic       w_blank_nxt;

  // Next counter position and sync/blank decode of that position, so the
  // registered outputs line up with the registered counters.
  always_comb begin
    w_x_wrap     = (r_x == H_LAST);
    w_frame_wrap = w_x_wrap && (r_y == V_LAST);
    w_x_nxt      = w_x_wrap ? '0 : r_x + 10'd1;
    w_y_nxt      = r_y;
    if (w_x_wrap) begin
      w_y_nxt = (r_y == V_LAST) ? '0 : r_y + 10'd1;
    end
    w_hs_nxt    = !((w_x_nxt >= HS_FIRST) && (w_x_nxt <= HS_LAST));
    w_vs_nxt    = !((w_y_nxt >= VS_FIRST) && (w_y_nxt <= VS_LAST));
    w_blank_nxt = (w_x_nxt < H_VIS) && (w_y_nxt < V_VIS);
  end

  // Counters, decoded outputs and frame bookkeeping; everything holds when
  // disabled except the frame pulse, which drops.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_x           <= '0;
      r_y           <= '0;
      r_hs          <= 1'b1;
      r_vs          <= 1'b1;
      r_blank       <= 1'b1;
      r_frame_start <= 1'b0;
      r_frame_count <= '0;
    end else if (en) begin
      r_x           <= w_x_nxt;
      r_y           <= w_y_nxt;
      r_hs          <= w_hs_nxt;
      r_vs          <= w_vs_nxt;
      r_blank       <= w_blank_nxt;
      r_frame_start <= w_frame_wrap;
      r_frame_count <= r_frame_count + 8'(w_frame_wrap);
    end else begin
      r_frame_start <= 1'b0;
    end
  end

  assign DrawX       = r_x;
  assign DrawY       = r_y;
  assign hs          = r_hs;
  assign vs          = r_vs;
  assign blank       = r_blank;
  assign frame_start = r_frame_start;
  assign frame_count = r_frame_count;

  // Keep the totals referenced for readability of the wrap points above.
  logic w_unused_totals;
  assign w_unused_totals = ^{H_TOTAL, V_TOTAL};

endmodule
